piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter that drives the single-bit serial input of the team's serial-in shift-register receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock0 cycle.
- Because the word is sent MSB first, the receiver holds the word with correct bit order exactly WIDTH cycles after the first bit.
- Sits between a parallel data source and the serial link. It supports back-to-back words or a programmable idle gap between words.

Parameters:
- WIDTH, 12, word length in bits (≥2); matches the receiver's register length.
- GAP_CYCLES, 0, forced idle cycles after each word before the next is accepted (0 = back-to-back allowed).

Ports:
- clock0  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  source has a word on load_data.
- load_ready  output  1  block will accept load_data this cycle.
- shift_out  output  1  serial data to the receiver's shift_in.
- frame  output  1  high while shift_out carries a valid data bit.
- last_bit  output  1  high during the cycle in which bit 0 of the current word is on shift_out.

Behaviour:
- Reset: when reset_n is low at a clock0 edge:
  - state goes to IDLE; shift_out, frame and last_bit all go to 0.
  - the bit counter and the gap counter clear.
  - load_ready is 0 in every cycle in which reset_n is low.
  - reset during SHIFT aborts the word immediately; no remaining bits are sent.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1, frame=0, shift_out=0.
  - A handshake occurs at an edge where load_valid && load_ready. It loads the shift register with load_data, clears bit_cnt and moves to SHIFT.
- SHIFT (latency and bit order):
  - The cycle after the handshake, shift_out = word[WIDTH-1] and frame=1.
  - Bit k (MSB=0th sent) is on shift_out in cycle T+1+k, where T is the handshake edge.
  - shift_out is registered (the MSB of the internal shift register). The register shifts left each cycle, and bit_cnt increments.
  - bit_cnt is $clog2(WIDTH) bits wide and counts 0..WIDTH-1.
  - last_bit=1 when bit_cnt==WIDTH-1.
  - load_data is sampled only at the handshake; later changes to it have no effect on the word in flight.
- End of word (bit_cnt==WIDTH-1):
  - If GAP_CYCLES==0: load_ready=1 in this cycle.
    - If load_valid is high, the new word is loaded and its MSB appears the next cycle. frame stays 1, with no bubble.
    - Otherwise the next state is IDLE.
  - If GAP_CYCLES>0: load_ready=0 in this cycle and the next state is GAP.
- GAP:
  - frame=0, shift_out=0, load_ready=0.
  - Lasts exactly GAP_CYCLES cycles, counted by gap_cnt, then goes to IDLE.
- load_ready in SHIFT is 0, except in the last-bit cycle when GAP_CYCLES==0.
- load_valid while load_ready=0 is ignored. The source must hold the word until it is accepted.
- If load_valid and reset_n low coincide, reset wins and nothing is loaded.
- Throughput:
  - one word per WIDTH cycles when GAP_CYCLES==0.
  - one word per WIDTH+GAP_CYCLES+1 cycles otherwise, counting the IDLE acceptance cycle.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with load_valid=1 -> load_ready=0, shift_out=0, frame=0 throughout. After release, load_ready=1 in IDLE.
- Single word (WIDTH=12, GAP=0): load 12'hA5C -> shift_out over the 12 cycles after the handshake = 1,0,1,0,0,1,0,1,1,1,0,0.
  - frame=1 for exactly those 12 cycles; last_bit=1 only on the 12th.
  - A receiver model of the same width connected to shift_out holds 12'hA5C when last_bit falls.
- Back-to-back (GAP=0): 12'hFFF then 12'h001, load_valid held high -> 24 contiguous frame=1 cycles.
  - Bits are twelve 1s, eleven 0s, then 1.
  - load_ready=1 only in IDLE and on the last-bit cycles.
- Gap (GAP_CYCLES=3): two words 12'h800, 12'h001 -> frame low for 3 GAP cycles plus 1 IDLE cycle between the words.
  - load_ready=0 in the GAP cycles.
  - The second word's MSB appears 16 cycles after the first word's MSB.
- Mid-word reset: load 12'hFFF and assert reset_n=0 at bit 5 -> shift_out=0 and frame=0 from the next cycle.
  - After release, 12'h0F0 transmits correctly from its MSB, with no residue of the aborted word.
- Handshake hold-off: assert load_valid with 12'h123 during SHIFT (GAP=0, not the last bit), then change load_data to 12'h456 before acceptance.
  - The in-flight word is unaffected.
  - The word accepted on the last-bit cycle is the value present at that edge (12'h456).

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB first, one bit per clock, with an optional idle gap between words.
module piso_serializer #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clock0,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             shift_out,
    output logic             frame,
    output logic             last_bit
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [GapW-1:0] LastGap = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              is_last;
    logic              accept;

    assign is_last   = (state_q == StShift) && (bit_cnt_q == LastCnt);
    // Zeros shift in behind the word, so the MSB reads 0 once the word has drained.
    assign shift_out = shreg_q[WIDTH-1];
    assign frame     = (state_q == StShift);
    assign last_bit  = is_last;

    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            StIdle:  load_ready = 1'b1;
            StShift: load_ready = is_last && (GAP_CYCLES == 0);
            default: load_ready = 1'b0;
        endcase
        load_ready = load_ready && reset_n;
        accept     = load_valid && load_ready;
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d   = load_data;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (is_last) begin
                    if (GAP_CYCLES == 0) begin
                        if (accept) begin
                            shreg_d   = load_data;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + GapW'(1);
                if (gap_cnt_q == LastGap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock0) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed scenarios on a back-to-back and a gapped instance,
// plus randomized traffic checked against a timeline model of each accepted word.
module tb_piso_serializer;

    localparam int W   = 12;
    localparam int GAP = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid;
    logic         a_ready, a_out, a_frame, a_last;
    logic         b_ready, b_out, b_frame, b_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut_a (
        .clock0    (clk),
        .reset_n   (reset_n),
        .load_data (a_data),
        .load_valid(a_valid),
        .load_ready(a_ready),
        .shift_out (a_out),
        .frame     (a_frame),
        .last_bit  (a_last)
    );

    piso_serializer #(.WIDTH(W), .GAP_CYCLES(GAP)) dut_b (
        .clock0    (clk),
        .reset_n   (reset_n),
        .load_data (b_data),
        .load_valid(b_valid),
        .load_ready(b_ready),
        .shift_out (b_out),
        .frame     (b_frame),
        .last_bit  (b_last)
    );

    // Observed vectors are {load_ready, shift_out, frame, last_bit}.
    wire [3:0] a_obs = {a_ready, a_out, a_frame, a_last};
    wire [3:0] b_obs = {b_ready, b_out, b_frame, b_last};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 12'hABC;
        b_data  = 12'h123;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (a_obs !== 4'b0000 || b_obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset cyc %0d: got a=%b b=%b expected 0000", k, a_obs, b_obs);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (a_obs !== 4'b1000 || b_obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got a=%b b=%b expected 1000", a_obs, b_obs);
        end
    endtask

    task automatic test_single_word;
        logic [W-1:0] w;
        logic [W-1:0] rx;
        logic [3:0]   exp;
        do_reset();
        w = 12'hA5C;
        rx = '0;
        a_data  = w;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_data  = 12'h000;
        for (int k = 0; k < W; k++) begin
            exp = {k == W - 1, w[W-1-k], 1'b1, k == W - 1};
            checks++;
            if (a_obs !== exp) begin
                errors++;
                $display("FAIL single bit %0d: got %b expected %b", k, a_obs, exp);
            end
            rx = {rx[W-2:0], a_out};
            tick();
        end
        checks++;
        if (rx !== w) begin
            errors++;
            $display("FAIL single_rx: got %h expected %h", rx, w);
        end
        checks++;
        if (a_obs !== 4'b1000) begin
            errors++;
            $display("FAIL single_idle: got %b expected 1000", a_obs);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        logic       lst;
        do_reset();
        a_data  = 12'hFFF;
        a_valid = 1'b1;
        tick();
        a_data = 12'h001;
        for (int k = 0; k < 2 * W; k++) begin
            if (k >= W) a_valid = 1'b0;
            lst = (k == W - 1) || (k == 2 * W - 1);
            exp = {lst, (k < W) || (k == 2 * W - 1), 1'b1, lst};
            checks++;
            if (a_obs !== exp) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b expected %b", k, a_obs, exp);
            end
            tick();
        end
        checks++;
        if (a_obs !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_idle: got %b expected 1000", a_obs);
        end
    endtask

    task automatic test_gap;
        logic [3:0] exp;
        do_reset();
        b_data  = 12'h800;
        b_valid = 1'b1;
        tick();
        b_data = 12'h001;
        for (int c = 0; c <= 2 * W + GAP + 1; c++) begin
            if (c > W + GAP) b_valid = 1'b0;
            if (c < W)                exp = {1'b0, c == 0, 1'b1, c == W - 1};
            else if (c < W + GAP)     exp = 4'b0000;
            else if (c == W + GAP)    exp = 4'b1000;
            else if (c <= 2 * W + GAP) exp = {1'b0, c == 2 * W + GAP, 1'b1, c == 2 * W + GAP};
            else                      exp = 4'b0000;
            checks++;
            if (b_obs !== exp) begin
                errors++;
                $display("FAIL gap cyc %0d: got %b expected %b", c, b_obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_midword_reset;
        logic [W-1:0] rx;
        logic [3:0]   exp;
        do_reset();
        a_data  = 12'hFFF;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            checks++;
            if (a_obs !== 4'b0110) begin
                errors++;
                $display("FAIL midrst bit %0d: got %b expected 0110", k, a_obs);
            end
            if (k < 5) tick();
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (a_obs !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_abort: got %b expected 0000", a_obs);
        end
        reset_n = 1'b1;
        a_data  = 12'h0F0;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        rx = '0;
        for (int k = 0; k < W; k++) begin
            exp = {k == W - 1, a_data[W-1-k], 1'b1, k == W - 1};
            checks++;
            if (a_obs !== exp) begin
                errors++;
                $display("FAIL midrst_next bit %0d: got %b expected %b", k, a_obs, exp);
            end
            rx = {rx[W-2:0], a_out};
            tick();
        end
        checks++;
        if (rx !== 12'h0F0) begin
            errors++;
            $display("FAIL midrst_rx: got %h expected 0f0", rx);
        end
    endtask

    task automatic test_holdoff;
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [3:0]   exp;
        do_reset();
        w0 = 12'hC3A;
        w1 = 12'h456;
        a_data  = w0;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            if (k == 3) begin
                a_data  = 12'h123;
                a_valid = 1'b1;
            end
            if (k == 7) a_data = w1;
            if (k == W) a_valid = 1'b0;
            if (k < W) exp = {k == W - 1, w0[W-1-k], 1'b1, k == W - 1};
            else       exp = {k == 2 * W - 1, w1[2*W-1-k], 1'b1, k == 2 * W - 1};
            checks++;
            if (a_obs !== exp) begin
                errors++;
                $display("FAIL holdoff cyc %0d: got %b expected %b", k, a_obs, exp);
            end
            tick();
        end
    endtask

    // Timeline model: the latest accepted word occupies cycles acc_c+1 .. acc_c+W, and the
    // next word can be taken from cycle acc_c+W (no gap) or acc_c+W+GAP+1 (gap).
    task automatic test_random(input bit sel);
        int           acc_c;
        int           lag;
        bit           have;
        bit           rst;
        bit           cur_v;
        bit           rdy;
        logic [W-1:0] acc_w;
        logic [W-1:0] cur_d;
        logic [3:0]   exp;
        logic [3:0]   obs;
        do_reset();
        lag   = sel ? GAP + 1 : 0;
        have  = 1'b0;
        cur_v = 1'b0;
        acc_c = 0;
        acc_w = '0;
        cur_d = '0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            reset_n = !rst;
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = W'($urandom);
            end
            if (sel) begin
                b_valid = cur_v;
                b_data  = cur_d;
                a_valid = 1'b0;
            end else begin
                a_valid = cur_v;
                a_data  = cur_d;
                b_valid = 1'b0;
            end
            #1;
            rdy = !have || (c >= acc_c + W + lag);
            exp = {rdy && !rst, 3'b000};
            if (have && c > acc_c && c <= acc_c + W) begin
                exp[2] = acc_w[W - c + acc_c];
                exp[1] = 1'b1;
                exp[0] = (c == acc_c + W);
            end
            obs = sel ? b_obs : a_obs;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random%0d cyc %0d: got %b expected %b", sel, c, obs, exp);
            end
            if (rst) begin
                have = 1'b0;
            end else if (cur_v && rdy) begin
                have  = 1'b1;
                acc_c = c;
                acc_w = cur_d;
                cur_v = 1'b0;
            end
            tick();
        end
        reset_n = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_gap();
        test_midword_reset();
        test_holdoff();
        test_random(1'b0);
        test_random(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
